monobit_bit_feeder: RTL and testbench

Upstream stage of the monobit frequency tester. It accepts bytes over a valid/ready handshake and buffers them in a 2-entry FIFO. It serialises each byte LSB-first into a one-bit-per-cycle stream for the monobit accumulator, with block framing (`bit_first`/`bit_last`) every `BLOCK_LEN` output bits. The downstream accumulator always accepts, so the output side has no backpressure.

---
 rtl/monobit_bit_feeder.sv | 141 ++++++++++++++
 tb/tb_monobit_bit_feeder.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/monobit_bit_feeder.sv
// Byte-to-bit feeder for the monobit tester: 2-entry input FIFO, LSB-first shifter, block framing.
// Optional von Neumann debiasing when MONOBIT_FEEDER_VN_EN is defined.
module monobit_bit_feeder #(
   parameter int BLOCK_LEN = 128,
   parameter int CNT_W     = 16
) (
   input  logic       i_clk,
   input  logic       i_rst_n,
   input  logic       i_ena,
   input  logic       i_clear,
   input  logic [7:0] i_in_data,
   input  logic       i_in_valid,
   output logic       o_in_ready,
   output logic       o_bit_out,
   output logic       o_bit_valid,
   output logic       o_bit_first,
   output logic       o_bit_last,
   output logic [7:0] o_blocks_done,
   output logic       o_busy
);

`ifdef MONOBIT_FEEDER_VN_EN
   localparam logic [3:0] SH_UNITS = 4'd4;
`else
   localparam logic [3:0] SH_UNITS = 4'd8;
`endif
   localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(BLOCK_LEN - 1);
   localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};

   logic [7:0]       r_fifo [2];
   logic             r_wr_ptr;
   logic             r_rd_ptr;
   logic [1:0]       r_fifo_cnt;
   logic [7:0]       r_sh_data;
   logic [3:0]       r_sh_cnt;
   logic [CNT_W-1:0] r_blk_cnt;
   logic             r_bit_out;
   logic             r_bit_valid;
   logic             r_bit_first;
   logic             r_bit_last;
   logic [7:0]       r_blocks_done;
   logic             r_busy;

   logic       w_in_ready;
   logic       w_push;
   logic       w_consume;
   logic       w_emit;
   logic       w_load;
   logic       w_blk_last;
   logic [7:0] w_sh_next;
   logic [1:0] w_fifo_cnt_n;
   logic [3:0] w_sh_cnt_n;

   // rst_n gates ready so the upstream never sees a grant while the block is held in reset
   assign w_in_ready = i_rst_n & i_ena & ~i_clear & (r_fifo_cnt != 2'd2);
   assign w_push     = i_in_valid & w_in_ready;
   assign w_consume  = i_ena & (r_sh_cnt != 4'd0);

`ifdef MONOBIT_FEEDER_VN_EN
   assign w_emit    = w_consume & (r_sh_data[0] ^ r_sh_data[1]);
   assign w_sh_next = {2'b00, r_sh_data[7:2]};
`else
   assign w_emit    = w_consume;
   assign w_sh_next = {1'b0, r_sh_data[7:1]};
`endif

   // reloading on the last unit keeps back-to-back bytes gap-free
   assign w_load = i_ena & (r_fifo_cnt != 2'd0) &
                   ((r_sh_cnt == 4'd0) | ((r_sh_cnt == 4'd1) & w_consume));

   assign w_fifo_cnt_n = r_fifo_cnt + {1'b0, w_push} - {1'b0, w_load};
   assign w_sh_cnt_n   = w_load ? SH_UNITS : (w_consume ? r_sh_cnt - 4'd1 : r_sh_cnt);
   assign w_blk_last   = (r_blk_cnt == LAST_IDX);

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_fifo[0]     <= 8'h00;
         r_fifo[1]     <= 8'h00;
         r_wr_ptr      <= 1'b0;
         r_rd_ptr      <= 1'b0;
         r_fifo_cnt    <= 2'd0;
         r_sh_data     <= 8'h00;
         r_sh_cnt      <= 4'd0;
         r_blk_cnt     <= '0;
         r_bit_out     <= 1'b0;
         r_bit_valid   <= 1'b0;
         r_bit_first   <= 1'b0;
         r_bit_last    <= 1'b0;
         r_blocks_done <= 8'h00;
         r_busy        <= 1'b0;
      end else if (i_clear) begin
         r_wr_ptr      <= 1'b0;
         r_rd_ptr      <= 1'b0;
         r_fifo_cnt    <= 2'd0;
         r_sh_data     <= 8'h00;
         r_sh_cnt      <= 4'd0;
         r_blk_cnt     <= '0;
         r_bit_out     <= 1'b0;
         r_bit_valid   <= 1'b0;
         r_bit_first   <= 1'b0;
         r_bit_last    <= 1'b0;
         r_blocks_done <= 8'h00;
         r_busy        <= 1'b0;
      end else begin
         if (w_push) begin
            r_fifo[r_wr_ptr] <= i_in_data;
            r_wr_ptr         <= ~r_wr_ptr;
         end
         if (w_load) begin
            r_rd_ptr  <= ~r_rd_ptr;
            r_sh_data <= r_fifo[r_rd_ptr];
         end else if (w_consume) begin
            r_sh_data <= w_sh_next;
         end
         r_fifo_cnt  <= w_fifo_cnt_n;
         r_sh_cnt    <= w_sh_cnt_n;
         r_bit_valid <= w_emit;
         r_bit_first <= w_emit & (r_blk_cnt == '0);
         r_bit_last  <= w_emit & w_blk_last;
         if (w_emit) begin
            r_bit_out <= r_sh_data[0];
            if (w_blk_last) begin
               r_blk_cnt     <= '0;
               r_blocks_done <= r_blocks_done + 8'd1;
            end else begin
               r_blk_cnt <= r_blk_cnt + CNT_ONE;
            end
         end
         r_busy <= (w_fifo_cnt_n != 2'd0) | (w_sh_cnt_n != 4'd0);
      end
   end

   assign o_in_ready    = w_in_ready;
   assign o_bit_out     = r_bit_out;
   assign o_bit_valid   = r_bit_valid;
   assign o_bit_first   = r_bit_first;
   assign o_bit_last    = r_bit_last;
   assign o_blocks_done = r_blocks_done;
   assign o_busy        = r_busy;

endmodule

// File: tb/tb_monobit_bit_feeder.sv
// Directed bench for monobit_bit_feeder: one instance with BLOCK_LEN=8, one with the default 128.
// Builds with or without MONOBIT_FEEDER_VN_EN and selects the matching scenarios.
module tb_monobit_bit_feeder;
   logic       clk = 1'b0;
   logic       rst_n;
   logic       ena;
   logic       clear;
   logic [7:0] in_data;
   logic       in_valid;

   logic       rdy8, bo8, bv8, bf8, bl8, busy8;
   logic [7:0] bd8;
   logic       rdy128, bo128, bv128, bf128, bl128, busy128;
   logic [7:0] bd128;

   int n_checks = 0;
   int n_fail   = 0;
   int cyc      = 0;

   int q8b[$], q8f[$], q8l[$], q8c[$];
   int q128b[$], q128f[$], q128l[$], q128c[$];

   always #5 clk = ~clk;
   always @(posedge clk) cyc++;

   monobit_bit_feeder #(.BLOCK_LEN(8), .CNT_W(4)) u_dut8 (
      .i_clk(clk), .i_rst_n(rst_n), .i_ena(ena), .i_clear(clear),
      .i_in_data(in_data), .i_in_valid(in_valid), .o_in_ready(rdy8),
      .o_bit_out(bo8), .o_bit_valid(bv8), .o_bit_first(bf8), .o_bit_last(bl8),
      .o_blocks_done(bd8), .o_busy(busy8)
   );

   monobit_bit_feeder u_dut128 (
      .i_clk(clk), .i_rst_n(rst_n), .i_ena(ena), .i_clear(clear),
      .i_in_data(in_data), .i_in_valid(in_valid), .o_in_ready(rdy128),
      .o_bit_out(bo128), .o_bit_valid(bv128), .o_bit_first(bf128), .o_bit_last(bl128),
      .o_blocks_done(bd128), .o_busy(busy128)
   );

   always @(negedge clk) begin
      if (bv8 === 1'b1) begin
         q8b.push_back(int'(bo8)); q8f.push_back(int'(bf8));
         q8l.push_back(int'(bl8)); q8c.push_back(cyc);
      end
      if (bv128 === 1'b1) begin
         q128b.push_back(int'(bo128)); q128f.push_back(int'(bf128));
         q128l.push_back(int'(bl128)); q128c.push_back(cyc);
      end
   end

   task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, act, exp);
      end
   endtask

   task automatic idle(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic flush_queues();
      q8b.delete(); q8f.delete(); q8l.delete(); q8c.delete();
      q128b.delete(); q128f.delete(); q128l.delete(); q128c.delete();
   endtask

   task automatic do_clear();
      clear = 1'b1;
      idle(1);
      clear = 1'b0;
      flush_queues();
   endtask

   // returns the cycle number of the accepting edge
   task automatic send_byte(input logic [7:0] b, output int t);
      logic ok;
      ok = 1'b0;
      in_data  = b;
      in_valid = 1'b1;
      for (int k = 0; k < 64 && !ok; k++) begin
         @(negedge clk);
         ok = rdy8;
         idle(1);
      end
      in_valid = 1'b0;
      t = cyc;
      if (!ok) chk("send_timeout", 32'd0, 32'd1);
   endtask

   function automatic logic [7:0] byte_of8(input int start);
      logic [7:0] v;
      v = 8'h00;
      for (int i = 0; i < 8; i++) if (q8b.size() > start + i) v[i] = q8b[start + i][0];
      return v;
   endfunction

   function automatic logic [7:0] byte_of128(input int start, input int nb);
      logic [7:0] v;
      v = 8'h00;
      for (int i = 0; i < nb; i++) if (q128b.size() > start + i) v[i] = q128b[start + i][0];
      return v;
   endfunction

   initial begin
      int t, t2, acc, lowcnt, gaps, ones, nfirst, nlast;
      logic rdy;
      rst_n = 1'b0; ena = 1'b0; clear = 1'b0; in_data = 8'h00; in_valid = 1'b0;

      // reset with random inputs
      for (int i = 0; i < 6; i++) begin
         @(posedge clk); #1;
         ena = 1'($urandom); clear = 1'($urandom);
         in_data = 8'($urandom); in_valid = 1'($urandom);
      end
      ena = 1'b1;
      #1;
      chk("rst_in_ready", 32'(rdy8), 32'd0);
      chk("rst_bit_out", 32'(bo8), 32'd0);
      chk("rst_bit_valid", 32'(bv8), 32'd0);
      chk("rst_bit_first", 32'(bf8), 32'd0);
      chk("rst_bit_last", 32'(bl8), 32'd0);
      chk("rst_blocks_done", 32'(bd8), 32'd0);
      chk("rst_busy", 32'(busy8), 32'd0);
      clear = 1'b0; in_valid = 1'b0;
      @(posedge clk); #1;
      rst_n = 1'b1;
      idle(2);
      flush_queues();
      chk("post_rst_in_ready", 32'(rdy8), 32'd1);
      chk("post_rst_busy", 32'(busy8), 32'd0);

`ifdef MONOBIT_FEEDER_VN_EN
      send_byte(8'h1E, t);
      idle(12);
      chk("vn_1e_count", 32'(q8b.size()), 32'd2);
      chk("vn_1e_bit0", 32'(q8b.size() > 0 ? q8b[0] : 9), 32'd0);
      chk("vn_1e_bit1", 32'(q8b.size() > 1 ? q8b[1] : 9), 32'd1);
      chk("vn_1e_first", 32'(q8f.size() > 0 ? q8f[0] : 9), 32'd1);
      chk("vn_1e_bit0_cyc", 32'(q8c.size() > 0 ? q8c[0] : 0), 32'(t + 2));
      send_byte(8'h00, t);
      send_byte(8'hFF, t);
      idle(16);
      chk("vn_00ff_count", 32'(q8b.size()), 32'd2);
      chk("vn_busy_end", 32'(busy8), 32'd0);
      chk("vn_blocks_done", 32'(bd8), 32'd0);
`else
      // single byte, BLOCK_LEN=8
      do_clear();
      send_byte(8'hA5, t);
      idle(12);
      nfirst = 0; nlast = 0;
      foreach (q8f[i]) nfirst += q8f[i];
      foreach (q8l[i]) nlast += q8l[i];
      chk("a5_count", 32'(q8b.size()), 32'd8);
      chk("a5_bits", 32'(byte_of8(0)), 32'hA5);
      chk("a5_first_cyc", 32'(q8c.size() > 0 ? q8c[0] : 0), 32'(t + 2));
      chk("a5_last_cyc", 32'(q8c.size() > 7 ? q8c[7] : 0), 32'(t + 9));
      chk("a5_first_flag", 32'(q8f.size() > 0 ? q8f[0] : 9), 32'd1);
      chk("a5_last_flag", 32'(q8l.size() > 7 ? q8l[7] : 9), 32'd1);
      chk("a5_nfirst", 32'(nfirst), 32'd1);
      chk("a5_nlast", 32'(nlast), 32'd1);
      chk("a5_blocks_done", 32'(bd8), 32'd1);
      chk("a5_busy", 32'(busy8), 32'd0);
      chk("a5_blocks_done128", 32'(bd128), 32'd0);

      // continuous 0xFF x20, BLOCK_LEN=128
      do_clear();
      acc = 0;
      in_data = 8'hFF; in_valid = 1'b1;
      for (int k = 0; k < 400 && acc < 20; k++) begin
         @(negedge clk);
         rdy = rdy8;
         idle(1);
         if (rdy) acc++;
      end
      in_valid = 1'b0;
      chk("ff_accepted", 32'(acc), 32'd20);
      idle(200);
      gaps = 0; ones = 0; nfirst = 0; nlast = 0;
      foreach (q128c[i]) begin
         if (q128c[i] != q128c[0] + i) gaps++;
         ones += q128b[i]; nfirst += q128f[i]; nlast += q128l[i];
      end
      chk("ff_count", 32'(q128b.size()), 32'd160);
      chk("ff_gaps", 32'(gaps), 32'd0);
      chk("ff_ones", 32'(ones), 32'd160);
      chk("ff_first0", 32'(q128f.size() > 0 ? q128f[0] : 9), 32'd1);
      chk("ff_first128", 32'(q128f.size() > 128 ? q128f[128] : 9), 32'd1);
      chk("ff_nfirst", 32'(nfirst), 32'd2);
      chk("ff_last127", 32'(q128l.size() > 127 ? q128l[127] : 9), 32'd1);
      chk("ff_nlast", 32'(nlast), 32'd1);
      chk("ff_blocks_done", 32'(bd128), 32'd1);

      // backpressure with distinct bytes 0x01..0x10
      do_clear();
      acc = 0; lowcnt = 0;
      in_data = 8'h01; in_valid = 1'b1;
      for (int k = 0; k < 600 && acc < 16; k++) begin
         @(negedge clk);
         rdy = rdy8;
         if (!rdy) lowcnt++;
         idle(1);
         if (rdy) begin
            acc++;
            in_data = 8'(acc + 1);
         end
      end
      in_valid = 1'b0;
      chk("bp_accepted", 32'(acc), 32'd16);
      chk("bp_ready_low_seen", 32'(lowcnt > 0), 32'd1);
      idle(150);
      chk("bp_count", 32'(q128b.size()), 32'd128);
      for (int i = 0; i < 16; i++) chk($sformatf("bp_byte%0d", i), 32'(byte_of128(8 * i, 8)), 32'(i + 1));
      chk("bp_blocks_done128", 32'(bd128), 32'd1);
      chk("bp_blocks_done8", 32'(bd8), 32'd16);

      // clear on the 4th bit of 0x3C, then 0x80
      do_clear();
      send_byte(8'h3C, t);
      idle(5);
      clear = 1'b1;
      idle(1);
      clear = 1'b0;
      idle(3);
      send_byte(8'h80, t2);
      idle(12);
      chk("clr_count", 32'(q128b.size()), 32'd12);
      chk("clr_partial", 32'(byte_of128(0, 4)), 32'h0C);
      chk("clr_next_byte", 32'(byte_of128(4, 8)), 32'h80);
      chk("clr_next_first", 32'(q128f.size() > 4 ? q128f[4] : 9), 32'd1);
      chk("clr_next_cyc", 32'(q128c.size() > 4 ? q128c[4] : 0), 32'(t2 + 2));
      chk("clr_blocks_done128", 32'(bd128), 32'd0);
      chk("clr_last8", 32'(q8l.size() > 11 ? q8l[11] : 9), 32'd1);
      chk("clr_blocks_done8", 32'(bd8), 32'd1);

      // ena low for 3 cycles mid-byte
      do_clear();
      send_byte(8'hA5, t);
      idle(4);
      ena = 1'b0;
      idle(3);
      ena = 1'b1;
      idle(12);
      chk("ena_count", 32'(q8b.size()), 32'd8);
      chk("ena_bits", 32'(byte_of8(0)), 32'hA5);
      chk("ena_bit2_cyc", 32'(q8c.size() > 2 ? q8c[2] : 0), 32'(t + 4));
      chk("ena_bit3_cyc", 32'(q8c.size() > 3 ? q8c[3] : 0), 32'(t + 8));
      chk("ena_bit7_cyc", 32'(q8c.size() > 7 ? q8c[7] : 0), 32'(t + 12));
      chk("ena_blocks_done", 32'(bd8), 32'd1);

      // reset mid-byte drops the rest
      do_clear();
      send_byte(8'hFF, t);
      idle(4);
      #6;
      rst_n = 1'b0;
      #3;
      chk("midrst_busy", 32'(busy8), 32'd0);
      rst_n = 1'b1;
      idle(20);
      chk("midrst_count", 32'(q8b.size()), 32'd3);
      chk("midrst_blocks_done", 32'(bd8), 32'd0);
`endif

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end
endmodule
